// File: rtl/return_stack_pkg.sv
// Shared definitions for the return-address stack.
//   OVF_DROP / OVF_WRAP : full-stack push policy encodings
//   cnt_width()         : width of the occupancy counter, clog2(depth+1)
//   ptr_inc / ptr_dec   : circular pointer step that wraps at depth
//                         (not at a power of two)
package return_stack_pkg;

   localparam int OVF_DROP = 0;
   localparam int OVF_WRAP = 1;

   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int ptr_inc(input int p, input int depth);
      return (p >= depth - 1) ? 0 : p + 1;
   endfunction

   function automatic int ptr_dec(input int p, input int depth);
      return (p == 0) ? depth - 1 : p - 1;
   endfunction

endpackage

// File: rtl/return_stack_mem.sv
// DEPTH x WIDTH storage for the return stack. Not reset.
// Ports:
//   clk   : write clock
//   we    : write enable, waddr/wdata written on the rising edge
//   raddr : asynchronous read address, rdata is combinational
module return_stack_mem #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/return_stack.sv
// Return-address stack: circular buffer with a write pointer and an
// occupancy count, sticky overflow/underflow flags and a selectable
// full-stack policy (drop the new push or overwrite the oldest entry).
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   push, pop, d      : call pushes d, return pops; both replaces the top
//   clr_err           : clears the sticky flags (a same-cycle error wins)
//   q                 : current top, 0 while empty
//   count/empty/full  : occupancy
//   overflow/underflow: sticky error flags
module return_stack
   import return_stack_pkg::*;
#(
   parameter int WIDTH    = 10,
   parameter int DEPTH    = 8,
   parameter int OVF_MODE = OVF_DROP
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          push,
   input  logic                          pop,
   input  logic [WIDTH-1:0]              d,
   input  logic                          clr_err,
   output logic [WIDTH-1:0]              q,
   output logic [cnt_width(DEPTH)-1:0]   count,
   output logic                          empty,
   output logic                          full,
   output logic                          overflow,
   output logic                          underflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = cnt_width(DEPTH);

   logic [PW-1:0]    wp_q, wp_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic [PW-1:0]    wp_inc, top_addr;
   logic             mem_we;
   logic [PW-1:0]    mem_waddr;
   logic [WIDTH-1:0] mem_rdata;

   assign wp_inc   = PW'(ptr_inc(int'(wp_q), DEPTH));
   assign top_addr = PW'(ptr_dec(int'(wp_q), DEPTH));

   assign empty     = (cnt_q == '0);
   assign full      = (cnt_q == CW'(DEPTH));
   assign count     = cnt_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;
   assign q         = empty ? '0 : mem_rdata;

   always_comb begin
      wp_d      = wp_q;
      cnt_d     = cnt_q;
      ovf_d     = clr_err ? 1'b0 : ovf_q;
      unf_d     = clr_err ? 1'b0 : unf_q;
      mem_we    = 1'b0;
      mem_waddr = wp_q;
      unique case ({push, pop})
         2'b10: begin
            if (!full) begin
               mem_we = 1'b1;
               wp_d   = wp_inc;
               cnt_d  = cnt_q + CW'(1);
            end else begin
               ovf_d = 1'b1;
               // Wrap mode: the slot after the top is the oldest entry.
               if (OVF_MODE == OVF_WRAP) begin
                  mem_we = 1'b1;
                  wp_d   = wp_inc;
               end
            end
         end
         2'b01: begin
            if (empty) begin
               unf_d = 1'b1;
            end else begin
               wp_d  = top_addr;
               cnt_d = cnt_q - CW'(1);
            end
         end
         2'b11: begin
            if (empty) begin
               unf_d = 1'b1;
            end else begin
               mem_we    = 1'b1;
               mem_waddr = top_addr;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wp_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         wp_q  <= wp_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   return_stack_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (d),
      .raddr (top_addr),
      .rdata (mem_rdata)
   );

endmodule

// File: tb/tb_return_stack.sv
module tb_return_stack;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // u0: DEPTH=4 drop mode, u1: DEPTH=3 wrap mode
   logic       reset0, push0, pop0, clr0;
   logic [9:0] d0, q0;
   logic [2:0] cnt0;
   logic       emp0, ful0, ovf0, unf0;

   logic       reset1, push1, pop1, clr1;
   logic [9:0] d1, q1;
   logic [1:0] cnt1;
   logic       emp1, ful1, ovf1, unf1;

   return_stack #(.WIDTH(10), .DEPTH(4), .OVF_MODE(0)) u0 (
      .clk(clk), .reset(reset0), .push(push0), .pop(pop0), .d(d0), .clr_err(clr0),
      .q(q0), .count(cnt0), .empty(emp0), .full(ful0), .overflow(ovf0), .underflow(unf0)
   );

   return_stack #(.WIDTH(10), .DEPTH(3), .OVF_MODE(1)) u1 (
      .clk(clk), .reset(reset1), .push(push1), .pop(pop1), .d(d1), .clr_err(clr1),
      .q(q1), .count(cnt1), .empty(emp1), .full(ful1), .overflow(ovf1), .underflow(unf1)
   );

   typedef struct {
      string      name;
      int         u;
      logic [9:0] q;
      logic [2:0] cnt;
      logic [3:0] fl;   // {empty, full, overflow, underflow}
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // Monitor: compares every pending expectation against the DUT on the falling edge.
   always @(negedge clk) begin
      while (sb.size() > 0) begin
         exp_t       e;
         logic [9:0] aq;
         logic [2:0] ac;
         logic [3:0] af;
         e = sb.pop_front();
         if (e.u == 0) begin
            aq = q0; ac = cnt0; af = {emp0, ful0, ovf0, unf0};
         end else begin
            aq = q1; ac = {1'b0, cnt1}; af = {emp1, ful1, ovf1, unf1};
         end
         n_chk++;
         if (aq !== e.q || ac !== e.cnt || af !== e.fl) begin
            n_fail++;
            $display("FAIL %s: got q=%h count=%0d e/f/o/u=%b, expected q=%h count=%0d e/f/o/u=%b",
                     e.name, aq, ac, af, e.q, e.cnt, e.fl);
         end
      end
   end

   task automatic expect_st(input string nm, input int u, input logic [9:0] eq,
                            input logic [2:0] ec, input logic [3:0] efl);
      exp_t e;
      e.name = nm; e.u = u; e.q = eq; e.cnt = ec; e.fl = efl;
      sb.push_back(e);
   endtask

   task automatic idle();
      push0 = 0; pop0 = 0; clr0 = 0; d0 = '0;
      push1 = 0; pop1 = 0; clr1 = 0; d1 = '0;
   endtask

   // One clocked operation: pp = {push, pop}
   task automatic st(input string nm, input int u, input logic [1:0] pp, input logic [9:0] dv,
                     input logic ce, input logic [9:0] eq, input logic [2:0] ec,
                     input logic [3:0] efl);
      @(negedge clk);
      if (u == 0) begin
         {push0, pop0} = pp; d0 = dv; clr0 = ce;
      end else begin
         {push1, pop1} = pp; d1 = dv; clr1 = ce;
      end
      @(posedge clk);
      #1;
      idle();
      expect_st(nm, u, eq, ec, efl);
   endtask

   localparam logic [1:0] PU = 2'b10, PO = 2'b01, PP = 2'b11, NO = 2'b00;

   initial begin
      idle();
      reset0 = 1; reset1 = 1;
      repeat (2) @(negedge clk);
      reset0 = 0; reset1 = 0;
      #1;
      expect_st("reset0", 0, 10'h000, 3'd0, 4'b1000);
      expect_st("reset1", 1, 10'h000, 3'd0, 4'b1000);

      // Case 1: pushes
      st("c1_push1", 0, PU, 10'h101, 0, 10'h101, 3'd1, 4'b0000);
      st("c1_push2", 0, PU, 10'h102, 0, 10'h102, 3'd2, 4'b0000);
      st("c1_push3", 0, PU, 10'h103, 0, 10'h103, 3'd3, 4'b0000);
      // Case 2: pops, then underflow
      st("c2_pop1",  0, PO, 10'h000, 0, 10'h102, 3'd2, 4'b0000);
      st("c2_pop2",  0, PO, 10'h000, 0, 10'h101, 3'd1, 4'b0000);
      st("c2_pop3",  0, PO, 10'h000, 0, 10'h000, 3'd0, 4'b1000);
      st("c2_unf",   0, PO, 10'h000, 0, 10'h000, 3'd0, 4'b1001);
      st("c2_idle",  0, NO, 10'h000, 0, 10'h000, 3'd0, 4'b1001);
      st("c2_clr",   0, NO, 10'h000, 1, 10'h000, 3'd0, 4'b1000);

      // Case 3: fill, overflow in drop mode, drain
      st("c3_push1", 0, PU, 10'h001, 0, 10'h001, 3'd1, 4'b0000);
      st("c3_push2", 0, PU, 10'h002, 0, 10'h002, 3'd2, 4'b0000);
      st("c3_push3", 0, PU, 10'h003, 0, 10'h003, 3'd3, 4'b0000);
      st("c3_push4", 0, PU, 10'h004, 0, 10'h004, 3'd4, 4'b0100);
      st("c3_ovf",   0, PU, 10'h005, 0, 10'h004, 3'd4, 4'b0110);
      st("c3_pop1",  0, PO, 10'h000, 0, 10'h003, 3'd3, 4'b0010);
      st("c3_pop2",  0, PO, 10'h000, 0, 10'h002, 3'd2, 4'b0010);
      st("c3_pop3",  0, PO, 10'h000, 0, 10'h001, 3'd1, 4'b0010);
      st("c3_pop4",  0, PO, 10'h000, 0, 10'h000, 3'd0, 4'b1010);

      // Case 4: wrap mode, DEPTH=3
      st("c4_push1", 1, PU, 10'h011, 0, 10'h011, 3'd1, 4'b0000);
      st("c4_push2", 1, PU, 10'h012, 0, 10'h012, 3'd2, 4'b0000);
      st("c4_push3", 1, PU, 10'h013, 0, 10'h013, 3'd3, 4'b0100);
      st("c4_wrap",  1, PU, 10'h014, 0, 10'h014, 3'd3, 4'b0110);
      st("c4_pop1",  1, PO, 10'h000, 0, 10'h013, 3'd2, 4'b0010);
      st("c4_pop2",  1, PO, 10'h000, 0, 10'h012, 3'd1, 4'b0010);
      st("c4_pop3",  1, PO, 10'h000, 0, 10'h000, 3'd0, 4'b1010);

      // Case 5: replace-top and push+pop on empty
      st("c5_clr",   0, NO, 10'h000, 1, 10'h000, 3'd0, 4'b1000);
      st("c5_push1", 0, PU, 10'h020, 0, 10'h020, 3'd1, 4'b0000);
      st("c5_push2", 0, PU, 10'h021, 0, 10'h021, 3'd2, 4'b0000);
      st("c5_repl",  0, PP, 10'h0AA, 0, 10'h0AA, 3'd2, 4'b0000);
      st("c5_pop1",  0, PO, 10'h000, 0, 10'h020, 3'd1, 4'b0000);
      st("c5_pop2",  0, PO, 10'h000, 0, 10'h000, 3'd0, 4'b1000);
      st("c5_ppemp", 0, PP, 10'h0CC, 0, 10'h000, 3'd0, 4'b1001);

      // Case 6: flag clear, set-wins, replace when full, async reset
      st("c6_clr",   0, NO, 10'h000, 1, 10'h000, 3'd0, 4'b1000);
      st("c6_push1", 0, PU, 10'h001, 0, 10'h001, 3'd1, 4'b0000);
      st("c6_push2", 0, PU, 10'h002, 0, 10'h002, 3'd2, 4'b0000);
      st("c6_push3", 0, PU, 10'h003, 0, 10'h003, 3'd3, 4'b0000);
      st("c6_push4", 0, PU, 10'h004, 0, 10'h004, 3'd4, 4'b0100);
      st("c6_ovf",   0, PU, 10'h005, 0, 10'h004, 3'd4, 4'b0110);
      st("c6_clrovf",0, NO, 10'h000, 1, 10'h004, 3'd4, 4'b0100);
      st("c6_replf", 0, PP, 10'h0BB, 0, 10'h0BB, 3'd4, 4'b0100);
      st("c6_setwin",0, PU, 10'h005, 1, 10'h0BB, 3'd4, 4'b0110);
      st("c6_pop",   0, PO, 10'h000, 0, 10'h003, 3'd3, 4'b0010);
      @(posedge clk);
      #2;
      reset0 = 1;
      expect_st("c6_async_rst", 0, 10'h000, 3'd0, 4'b1000);
      @(negedge clk);
      #1;
      reset0 = 0;
      st("c6_after", 0, PU, 10'h0DD, 0, 10'h0DD, 3'd1, 4'b0000);

      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/return_stack.md
Name: return_stack

Overview:
Parametrised hardware return-address stack for the microcontroller datapath. It replaces the single-entry return register so subroutine calls can nest up to DEPTH levels.
- Sits between the PC logic and the PC-source mux.
- Call pushes the return address; return pops it; q always presents the current top.
- Adds occupancy reporting, sticky overflow/underflow flags and a selectable full-stack policy.

Parameters:
WIDTH, 10, bit width of each stored address (matches PC width).
DEPTH, 8, number of entries; any integer >= 2, need not be a power of two.
OVF_MODE, 0, full-stack push policy: 0 = drop (discard new push), 1 = wrap (overwrite oldest entry).

Ports:
clk  input  1  system clock; all state changes on rising edge.
reset  input  1  asynchronous, active-high reset.
push  input  1  push d this cycle (call).
pop  input  1  pop top this cycle (return).
d  input  WIDTH  address to push.
clr_err  input  1  synchronous clear of overflow/underflow.
q  output  WIDTH  current top of stack, combinational from state; 0 when empty.
count  output  $clog2(DEPTH+1)  number of valid entries, 0..DEPTH.
empty  output  1  count == 0.
full  output  1  count == DEPTH.
overflow  output  1  sticky: a push was attempted while full.
underflow  output  1  sticky: a pop (or push+pop) was attempted while empty.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - count = 0, write pointer wp = 0, overflow = 0, underflow = 0.
  - Outputs: q = 0, empty = 1, full = 0.
  - Storage array is not reset; q is forced to 0 while empty.
- Storage is a circular buffer: wp is the next write slot; top = mem[(wp-1) mod DEPTH].
  - Pointer arithmetic wraps explicitly at DEPTH, not at a power of two.
- Read latency is 0: q reflects the state after the last clock edge.
- Operation per rising edge, selected by {push, pop}:
  - 00: no change.
  - 10, not full: mem[wp] <= d; wp++ (wrap); count++. The next cycle q = d.
  - 10, full, OVF_MODE=0: state unchanged; overflow <= 1.
  - 10, full, OVF_MODE=1: mem[wp] <= d; wp++; count stays DEPTH; overflow <= 1. The oldest entry is lost.
  - 01, not empty: wp-- (wrap); count--. Data is not erased.
  - 01, empty: state unchanged; underflow <= 1; q stays 0.
  - 11, not empty: replace top, mem[(wp-1) mod DEPTH] <= d; wp and count unchanged. The next cycle q = d. Full does not matter and does not set overflow.
  - 11, empty: state unchanged; underflow <= 1.
- clr_err clears both sticky flags on the edge. If an error event occurs in the same cycle, the set wins.
- Flags never self-clear except via clr_err or reset.
- count, empty and full are derived from the count register only; no extra pipeline stage.

Decomposition:
- Shared package return_stack_pkg holds:
  - OVF_MODE encodings OVF_DROP = 0 and OVF_WRAP = 1;
  - a function computing the count width, clog2(DEPTH+1);
  - the pointer-wrap increment/decrement helpers.
- One sub-module, return_stack_mem: DEPTH x WIDTH storage with one synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
- The top level keeps the pointer, count and flag logic.

Test Plan:
Unless noted, WIDTH=10, DEPTH=4, OVF_MODE=0.
1. Reset, then push 0x101, 0x102, 0x103 on consecutive cycles -> q = 0x101, 0x102, 0x103 after each edge; count = 3; empty = 0; full = 0.
2. From case 1, pop x3 -> q = 0x102, 0x101, 0 in turn; count = 0; empty = 1; one further pop sets underflow = 1 and count stays 0.
3. Push 0x001..0x004 (full = 1), then push 0x005 -> overflow = 1, q = 0x004, count = 4; pop x4 returns 0x004, 0x003, 0x002, 0x001.
4. OVF_MODE=1, DEPTH=3 (non-power-of-2): push 0x011, 0x012, 0x013, 0x014 -> count = 3, overflow = 1, q = 0x014; pop x3 yields 0x013, 0x012 and then empty. Confirms wrap mode and mod-3 pointer wrap.
5. With 2 entries (0x020, 0x021), assert push+pop with d = 0x0AA -> q = 0x0AA, count = 2, no flags; pop -> q = 0x020. Then on an empty stack, push+pop -> underflow = 1, count = 0.
6. Set overflow, then assert clr_err alone -> flag = 0. Assert clr_err with an overflowing push in the same cycle -> overflow = 1. Assert reset asynchronously mid-clock with count = 3 -> count = 0, q = 0 and flags = 0 immediately, before the next edge.
